// File: rtl/pixel_streamer.sv
// pixel_streamer: frame buffer played back in raster order, one pixel per divided-clock period.
module pixel_streamer #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DIV    = 6,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  output logic [7:0]        pixel_out,
  output logic              pixel_valid,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              slow_clk_out,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = $clog2(DIV);
  localparam int COL_W = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int ROW_W = IMG_H > 1 ? $clog2(IMG_H) : 1;
  typedef enum logic [1:0] {IDLE, ARM, STREAM, DONE} state_t;
  state_t state;
  logic [7:0] mem [2**ADDR_W];
  logic [CNT_W-1:0] cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [ADDR_W-1:0] idx, nidx;
  logic upd, wrap, last, col_last;
  assign upd      = cnt == CNT_W'(DIV/2-1);
  assign wrap     = cnt == CNT_W'(DIV-1);
  assign last     = idx == ADDR_W'(IMG_W*IMG_H-1);
  assign col_last = col == COL_W'(IMG_W-1);
  assign nidx     = idx + 1'b1;
  assign busy     = state != IDLE;
  // Buffer has no reset so a frame survives rst.
  always_ff @(posedge clk)
    if (wr_en && state == IDLE) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      slow_clk_out <= 1'b0;
      col          <= '0;
      row          <= '0;
      idx          <= '0;
      pixel_out    <= '0;
      pixel_valid  <= 1'b0;
      sof          <= 1'b0;
      eol          <= 1'b0;
      eof          <= 1'b0;
      done         <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      done <= 1'b0;
      if (wrap) slow_clk_out <= 1'b1;
      else if (upd) slow_clk_out <= 1'b0;
      case (state)
        IDLE: if (start) state <= ARM;
        ARM: if (upd) begin
          state       <= STREAM;
          pixel_out   <= mem[0];
          pixel_valid <= 1'b1;
          sof         <= 1'b1;
          eol         <= IMG_W == 1;
          eof         <= IMG_W*IMG_H == 1;
          col         <= '0;
          row         <= '0;
          idx         <= '0;
        end
        STREAM: if (upd) begin
          if (last) begin
            state       <= DONE;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
            done        <= 1'b1;
            col         <= '0;
            row         <= '0;
            idx         <= '0;
          end else begin
            col       <= col_last ? '0 : col + 1'b1;
            row       <= col_last ? row + 1'b1 : row;
            idx       <= nidx;
            pixel_out <= mem[nidx];
            sof       <= 1'b0;
            eol       <= col_last ? IMG_W == 1 : (col + 1'b1) == COL_W'(IMG_W-1);
            eof       <= nidx == ADDR_W'(IMG_W*IMG_H-1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer: cycle-by-cycle check of pixel_streamer against a timing-arithmetic reference model.
module tb_pixel_streamer;
  localparam int W = 8, H = 8, DIV = 6, N = W*H;
  logic clk = 0, rst = 1, wr_en = 0, start = 0;
  logic [5:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] pixel_out;
  logic pixel_valid, sof, eol, eof, slow_clk_out, busy, done;
  int checks = 0, errors = 0;
  logic [7:0] mm [N];
  int k = 0, s = 0, fu = 0;
  bit act = 0, eb = 0;
  logic [7:0] e_pix;
  logic e_v, e_sof, e_eol, e_eof, e_slow, e_busy, e_done;

  pixel_streamer #(.IMG_W(W), .IMG_H(H), .DIV(DIV), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .pixel_out(pixel_out), .pixel_valid(pixel_valid), .sof(sof),
    .eol(eol), .eof(eof), .slow_clk_out(slow_clk_out), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at k=%0d got %0h exp %0h", tag, k, got, exp);
    end
  endtask

  // Advance one fast cycle; expected outputs follow from edge count since reset.
  task automatic step();
    int d, p;
    if (rst) begin
      k = 0;
      act = 0;
    end else begin
      k++;
      if (wr_en && !eb) mm[wr_addr] = wr_data;
      if (start && !eb) begin
        act = 1;
        s = k;
        fu = k + 1;
        while (fu % DIV != DIV/2) fu++;
      end
    end
    @(posedge clk);
    #1;
    {e_pix, e_v, e_sof, e_eol, e_eof, e_busy, e_done} = '0;
    if (act && k >= s) begin
      if (k < fu) e_busy = 1;
      else begin
        d = k - fu;
        p = d / DIV;
        if (p < N) begin
          e_busy = 1; e_v = 1; e_pix = mm[p];
          e_sof = p == 0; e_eol = p % W == W-1; e_eof = p == N-1;
        end else if (d == N*DIV) begin
          e_busy = 1; e_done = 1;
        end else act = 0;
      end
    end
    e_slow = k >= DIV && k % DIV < DIV/2;
    eb = e_busy;
    chk("pixel_out", pixel_out, e_pix);
    chk("pixel_valid", 8'(pixel_valid), 8'(e_v));
    chk("sof", 8'(sof), 8'(e_sof));
    chk("eol", 8'(eol), 8'(e_eol));
    chk("eof", 8'(eof), 8'(e_eof));
    chk("slow_clk", 8'(slow_clk_out), 8'(e_slow));
    chk("busy", 8'(busy), 8'(e_busy));
    chk("done", 8'(done), 8'(e_done));
  endtask

  task automatic run_frame();
    for (int i = 0; i < N*DIV + 3*DIV && act; i++) step();
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  initial begin
    repeat (5) step();
    rst = 0;
    repeat (12) step();
    for (int i = 0; i < N; i++) begin
      wr_en = 1; wr_addr = 6'(i); wr_data = 8'(i);
      step();
    end
    wr_en = 0;
    pulse_start();
    run_frame();
    // Start and write during a frame must both be ignored.
    pulse_start();
    repeat (50) step();
    start = 1; wr_en = 1; wr_addr = 6'd5; wr_data = 8'hAA;
    step();
    start = 0; wr_en = 0;
    run_frame();
    step();
    pulse_start();
    run_frame();
    // Reset after pixel 20 is presented.
    pulse_start();
    for (int i = 0; i < N*DIV && !(act && k == fu + 20*DIV); i++) step();
    rst = 1;
    step();
    rst = 0;
    repeat (3) step();
    pulse_start();
    run_frame();
    // Write to addr 0 in the same cycle as start.
    start = 1; wr_en = 1; wr_addr = 6'd0; wr_data = 8'hFF;
    step();
    start = 0; wr_en = 0;
    run_frame();
    // Back-to-back: start held through DONE (ignored) into first IDLE cycle.
    pulse_start();
    for (int i = 0; i < N*DIV + 2*DIV && !e_done; i++) step();
    start = 1;
    step();
    step();
    start = 0;
    run_frame();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        wr_en = 1; wr_addr = 6'(i); wr_data = 8'($urandom);
        step();
      end
      wr_en = 0;
      repeat ($urandom_range(0, DIV-1)) step();
      pulse_start();
      run_frame();
    end
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
